// File: rtl/tpi_bus_master.sv
// Host-side initiator for a 6523-style TPI register bus.
//
// A free-running phase counter produces phi2 (PHI_HALF clocks low, then
// PHI_HALF clocks high). A single request is latched in IDLE, waits in WAIT
// for the next phi2 fall, then occupies exactly one full phi2 period in BUS.
// All bus and status outputs are registered.
//
// Handshake: req is sampled only while busy=0. An accepted request raises
// busy on the next edge. Completion is a one-clock ack, with err and rdata
// valid in that same clock. busy drops in that same clock, so a new req may
// be presented during the ack clock and is accepted there.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=WAIT, 2=BUS.
module tpi_bus_master #(
  parameter int PHI_HALF = 4
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       phi2,
  output logic       _cs,
  output logic [2:0] rs,
  output logic       _write,
  inout  wire  [7:0] data,
  output logic [1:0] dbg_state
);

  localparam int             CW       = $clog2(2 * PHI_HALF);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2 * PHI_HALF - 1);
  localparam logic [CW-1:0]  CNT_HIGH = CW'(PHI_HALF);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] BUS  = 2'd2;

  logic [CW-1:0] r_cnt;
  logic          r_phi2;
  logic [1:0]    r_state;
  logic          r_we;
  logic [2:0]    r_addr;
  logic [7:0]    r_wdata;
  logic          r_busy;
  logic          r_ack;
  logic          r_err;
  logic [7:0]    r_rdata;
  logic          r_cs_n;
  logic [2:0]    r_rs;
  logic          r_write_n;
  logic          r_drive;

  logic          w_wrap;
  logic [CW-1:0] w_cnt_next;

  // The edge where cnt==2*PHI_HALF-1 is the phi2 falling edge (wrap to 0).
  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;

  // Free-running phase counter; phi2 registered from the next count so it
  // always equals (cnt >= PHI_HALF) and falls exactly at the wrap.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_cnt  <= '0;
      r_phi2 <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_phi2 <= (w_cnt_next >= CNT_HIGH);
    end
  end

  // Transaction FSM: latch request, align to phi2 fall, run one bus period.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_addr    <= 3'd0;
      r_wdata   <= 8'd0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 8'd0;
      r_cs_n    <= 1'b1;
      r_rs      <= 3'd0;
      r_write_n <= 1'b1;
      r_drive   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_wrap) begin
            r_state   <= BUS;
            r_cs_n    <= 1'b0;
            r_rs      <= r_addr;
            r_write_n <= !r_we;
            r_drive   <= r_we;
          end
        end
        BUS: begin
          if (w_wrap) begin
            // phi2 is still high here, so a responder is still driving data.
            if (!r_we) begin
              r_rdata <= data;
            end
            r_state   <= IDLE;
            r_cs_n    <= 1'b1;
            r_write_n <= 1'b1;
            r_drive   <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= (r_addr >= 3'd6);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data      = r_drive ? r_wdata : 8'hzz;
  assign busy      = r_busy;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign phi2      = r_phi2;
  assign _cs       = r_cs_n;
  assign rs        = r_rs;
  assign _write    = r_write_n;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tpi_bus_master.sv
// Testbench for tpi_bus_master: drives register-bus requests into the master,
// models a TPI responder on the bus side, and checks every completion
// against a reference memory and a phase-based latency rule.
module tb_tpi_bus_master;

  localparam int P   = 4;
  localparam int PER = 2 * P;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic _reset = 1'b0;
  always #5 clock = ~clock;

  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, ack, err, phi2, _cs, _write;
  logic [7:0] rdata;
  logic [2:0] rs;
  logic [1:0] dbg_state;
  wire  [7:0] data;

  tpi_bus_master #(.PHI_HALF(P)) dut (
    .clock(clock), ._reset(_reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .phi2(phi2), ._cs(_cs), .rs(rs), ._write(_write), .data(data),
    .dbg_state(dbg_state)
  );

  // ---------------- responder model ----------------
  logic [7:0] resp_reg [0:7];
  always @(posedge phi2) begin
    if (!_cs && !_write && rs < 3'd6) resp_reg[rs] <= data;
  end
  assign data = (!_cs && _write && phi2 && rs < 3'd6) ? resp_reg[rs] : 8'hzz;

  // ---------------- phase model and edge counter ----------------
  int cnt_m = 0;
  int edge_n = 0;
  always @(posedge clock or negedge _reset) begin
    if (!_reset) cnt_m <= 0;
    else         cnt_m <= (cnt_m + 1) % PER;
  end
  always @(posedge clock) edge_n <= edge_n + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        w;
    logic [2:0]  a;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic        er;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] ref_mem [0:7];
  logic [7:0] last_rdata = 8'd0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_cs = 1'b1;
  int   cs_len  = 0;
  always @(negedge clock) begin
    if (!_reset) begin
      prev_cs = 1'b1;
      cs_len  = 0;
    end else begin
      exp_t e;
      chk("phi2_phase", {31'd0, phi2}, {31'd0, (cnt_m >= P)});
      if (!_cs) begin
        cs_len++;
        if (prev_cs) chk("cs_fall_at_wrap", cnt_m, 0);
        if (exp_q.size() == 0) begin
          chk("cs_low_without_txn", {31'd0, _cs}, 32'd1);
        end else begin
          e = exp_q[0];
          chk("bus_write_n", {31'd0, _write}, {31'd0, !e.w});
          chk("bus_rs", {29'd0, rs}, {29'd0, e.a});
          if (e.w) chk("bus_wdata", {24'd0, data}, {24'd0, e.d});
        end
      end else if (!prev_cs) begin
        chk("cs_low_len", cs_len, PER);
        cs_len = 0;
      end
      prev_cs = _cs;

      if (ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", {31'd0, ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_err", {31'd0, err}, {31'd0, e.er});
          chk("ack_latency", edge_n - e.acc, e.lat);
          chk("ack_busy_low", {31'd0, busy}, 32'd0);
          if (e.w) begin
            chk("rdata_hold_on_write", {24'd0, rdata}, {24'd0, last_rdata});
          end else if (!e.er) begin
            chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
            last_rdata = rdata;
          end else begin
            last_rdata = rdata;  // unspecified value for unmapped registers
          end
        end
      end else begin
        chk("err_idle", {31'd0, err}, 32'd0);
      end

      if (exp_q.size() == 0) begin
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_cs", {31'd0, _cs}, 32'd1);
        chk("idle_state", {30'd0, dbg_state}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request; phase>=0 delays it until the model counter equals
  // phase in the request cycle.
  task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input int phase);
    exp_t e;
    int   guard = 0;
    int   c;
    int   wait_clk;
    @(negedge clock);
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) chk("busy_timeout", {31'd0, busy}, 32'd0);
    if (phase >= 0) begin
      guard = 0;
      while (cnt_m != phase && guard < PER + 1) begin
        @(negedge clock);
        guard++;
      end
    end
    c        = cnt_m;
    wait_clk = (c == PER - 1) ? PER : (PER - 1 - c);
    e.w   = w;
    e.a   = a;
    e.d   = d;
    e.rd  = ref_mem[a];
    e.er  = (a >= 3'd6);
    e.acc = edge_n + 1;
    e.lat = wait_clk + PER;
    exp_q.push_back(e);
    if (w && a < 3'd6) ref_mem[a] = d;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clock);
    #1;
    req = 1'b0;
  endtask

  // Pulse req while a transaction is outstanding; these must be ignored.
  task automatic pulse_ignored(input int n);
    repeat (n) begin
      @(negedge clock);
      if (busy) begin
        req   = 1'b1;
        we    = 1'($urandom_range(0, 1));
        addr  = 3'($urandom_range(0, 7));
        wdata = 8'($urandom_range(0, 255));
        @(posedge clock);
        #1;
        req = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) chk("idle_timeout", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] old4;
    logic [7:0] old_ref;
    int         guard;
    for (int i = 0; i < 8; i++) begin
      resp_reg[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_phi2", {31'd0, phi2}, 32'd0);
    chk("rst_cs", {31'd0, _cs}, 32'd1);
    chk("rst_write", {31'd0, _write}, 32'd1);
    chk("rst_rs", {29'd0, rs}, 32'd0);
    _reset = 1'b1;

    // Idle phi2 running with no requests
    repeat (20) @(negedge clock);

    // Directed writes and reads
    issue(1'b1, 3'd3, 8'hFF, -1);
    issue(1'b1, 3'd0, 8'hA5, -1);
    issue(1'b1, 3'd1, 8'h3C, -1);
    issue(1'b0, 3'd1, 8'h00, -1);
    wait_idle();
    chk("resp_port_a", {24'd0, resp_reg[0]}, 32'hA5);
    chk("resp_ddra", {24'd0, resp_reg[3]}, 32'hFF);
    chk("last_read", {24'd0, rdata}, 32'h3C);

    // Latency at chosen request phases, with ignored pulses while busy
    issue(1'b0, 3'd0, 8'h00, PER - 2);
    pulse_ignored(6);
    wait_idle();
    issue(1'b0, 3'd3, 8'h00, PER - 1);
    pulse_ignored(10);
    wait_idle();
    issue(1'b1, 3'd2, 8'h81, 0);
    wait_idle();

    // Unmapped register then mapped
    issue(1'b0, 3'd6, 8'h00, -1);
    issue(1'b0, 3'd2, 8'h00, -1);
    wait_idle();

    // Randomized traffic, including back-to-back requests in the ack clock
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6);
      if (gap == 0) begin
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), -1);
      end else begin
        repeat (gap) @(negedge clock);
        issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), int'($urandom_range(0, PER - 1)));
      end
      if ($urandom_range(0, 4) == 0) pulse_ignored(3);
    end
    wait_idle();

    // Asynchronous reset in the phi2-low half of a write bus cycle
    old4    = resp_reg[4];
    old_ref = ref_mem[4];
    issue(1'b1, 3'd4, ~old4, -1);
    guard = 0;
    while (!(!_cs && cnt_m == 1) && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    chk("reach_bus_low_half", {31'd0, _cs}, 32'd0);
    _reset = 1'b0;
    #1;
    chk("arst_cs", {31'd0, _cs}, 32'd1);
    chk("arst_phi2", {31'd0, phi2}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ack", {31'd0, ack}, 32'd0);
    chk("arst_write", {31'd0, _write}, 32'd1);
    exp_q.delete();
    ref_mem[4] = old_ref;
    last_rdata = 8'd0;
    repeat (3) @(negedge clock);
    chk("arst_resp_unchanged", {24'd0, resp_reg[4]}, {24'd0, old4});
    chk("arst_rdata", {24'd0, rdata}, 32'd0);
    chk("arst_ack_held", {31'd0, ack}, 32'd0);
    _reset = 1'b1;

    // Recovery after reset
    issue(1'b1, 3'd5, 8'h5A, -1);
    issue(1'b0, 3'd5, 8'h00, -1);
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
